// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if -- fetch-unit bundle: pipeline control, redirect strobes,
// instruction-memory handshake and fetch results.
//   master : the fetch unit (drives instr_req, pc, pc_plus4, fetch_valid,
//            fetch_pc, stall_cycles; samples everything else)
//   slave  : the surrounding pipeline / memory (the mirror image)
interface pc_fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        instr_ack;
  logic        instr_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] stall_cycles;

  modport master (
    input  stall, branch_taken, branch_offset, jump, jump_index, instr_ack,
    output instr_req, pc, pc_plus4, fetch_valid, fetch_pc, stall_cycles
  );

  modport slave (
    output stall, branch_taken, branch_offset, jump, jump_index, instr_ack,
    input  instr_req, pc, pc_plus4, fetch_valid, fetch_pc, stall_cycles
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit -- program counter and instruction-fetch request FSM.
//   clk    : single clock, rising edge
//   reset  : synchronous, active high; pc <- RESET_PC, FSM -> REQ
//   bus    : pc_fetch_unit_if.master (stall, branch/jump strobes, instr_ack in;
//            instr_req, pc, pc_plus4, fetch_valid, fetch_pc, stall_cycles out)
// Optional feature: define PC_STALL_COUNT_EN to build the WAIT-cycle counter
// behind stall_cycles; otherwise stall_cycles is tied to zero.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  pc_fetch_unit_if.master bus
);
  localparam int STAGES = 1;

  typedef enum logic {S_REQ, S_WAIT} state_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] tgt;
  } redir_t;

  state_t            state, state_nxt;
  logic [31:0]       pc_q, pc_plus4, pc_nxt, fetch_pc_q;
  logic [31:0]       br_tgt, jmp_tgt;
  redir_t            strobe, pend_q;
  logic              upd, instr_req;
  logic [STAGES:0]   vld_pipe;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 + (bus.branch_offset << 2);
  assign jmp_tgt  = {pc_plus4[31:28], bus.jump_index, 2'b00};

  // Redirect seen this cycle; jump wins over branch.
  always_comb begin
    strobe.vld = bus.jump | bus.branch_taken;
    strobe.tgt = bus.jump ? jmp_tgt : br_tgt;
  end

  // A fresh strobe beats an older pending target.
  always_comb begin
    pc_nxt = pc_plus4;
    if (strobe.vld)      pc_nxt = strobe.tgt;
    else if (pend_q.vld) pc_nxt = pend_q.tgt;
  end

  always_comb begin
    state_nxt   = state;
    upd         = 1'b0;
    instr_req   = 1'b0;
    vld_pipe[0] = 1'b0;
    case (state)
      S_REQ: begin
        instr_req = 1'b1;
        if (bus.instr_ack) begin
          // Accepted request completes even if the pipe stalls.
          vld_pipe[0] = 1'b1;
          if (bus.stall) state_nxt = S_WAIT;
          else           upd = 1'b1;
        end
      end
      S_WAIT: begin
        // instr_ack is ignored here: nothing is outstanding.
        if (!bus.stall) begin
          upd       = 1'b1;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_REQ;
      pc_q               <= RESET_PC;
      pend_q             <= '0;
      vld_pipe[STAGES:1] <= '0;
      fetch_pc_q         <= '0;
    end else begin
      state              <= state_nxt;
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (upd) pc_q <= pc_nxt;
      // Strobes that cannot be consumed now are remembered; latest wins.
      if (upd)             pend_q.vld <= 1'b0;
      else if (strobe.vld) pend_q     <= strobe;
      if (vld_pipe[0]) fetch_pc_q <= pc_q;
    end
  end

`ifdef PC_STALL_COUNT_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (reset)                stall_cnt_q <= '0;
    else if (state == S_WAIT) stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign bus.stall_cycles = stall_cnt_q;
`else
  assign bus.stall_cycles = '0;
`endif

  assign bus.instr_req   = instr_req;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_valid = vld_pipe[STAGES];
  assign bus.fetch_pc    = fetch_pc_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit -- directed scenarios for pc_fetch_unit. Each accepted
// request pushes its expected fetch_pc; a negedge monitor pops on fetch_valid.
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] exp_q[$];

  pc_fetch_unit_if bus();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

`ifdef PC_STALL_COUNT_EN
  localparam logic [31:0] EXP_STALLS = 32'd3;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, settle 1 time unit.
  task automatic cyc(input logic ack, input logic stl, input logic br,
                     input logic [31:0] off, input logic jmp, input logic [25:0] idx);
    bus.instr_ack     = ack;
    bus.stall         = stl;
    bus.branch_taken  = br;
    bus.branch_offset = off;
    bus.jump          = jmp;
    bus.jump_index    = idx;
    @(posedge clk);
    #1;
  endtask

  task automatic ack1(input logic [31:0] exp_fpc);
    exp_q.push_back(exp_fpc);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
  endtask

  always @(negedge clk) begin
    if (bus.fetch_valid) begin
      if (exp_q.size() == 0) chk("unexpected_fetch_valid", bus.fetch_pc, 32'hxxxx_xxxx);
      else                   chk("fetch_pc", bus.fetch_pc, exp_q.pop_front());
    end
  end

  initial begin
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    reset = 1'b0;
    chk("rst_pc",        bus.pc,           32'h0);
    chk("rst_pc_plus4",  bus.pc_plus4,     32'h4);
    chk("rst_instr_req", {31'd0, bus.instr_req},   32'd1);
    chk("rst_fvalid",    {31'd0, bus.fetch_valid}, 32'd0);
    chk("rst_fetch_pc",  bus.fetch_pc,     32'h0);
    chk("rst_stalls",    bus.stall_cycles, 32'h0);

    // Sequential fetch.
    ack1(32'h0); ack1(32'h4); ack1(32'h8);
    chk("seq_pc", bus.pc, 32'hC);

    // Back to pc=8, then stall with ack held for 3 cycles.
    reset = 1'b1; cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0); reset = 1'b0;
    ack1(32'h0); ack1(32'h4);
    chk("pre_stall_pc", bus.pc, 32'h8);
    exp_q.push_back(32'h8);
    cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
    chk("stall_req", {31'd0, bus.instr_req}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
    chk("stall_pc", bus.pc, 32'h8);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    chk("release_pc",  bus.pc, 32'hC);
    chk("release_req", {31'd0, bus.instr_req}, 32'd1);
    chk("stall_count", bus.stall_cycles, EXP_STALLS);

    // Jump to 0x100, then branch without ack -> pending.
    exp_q.push_back(32'hC);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 26'h40);
    chk("jump_pc", bus.pc, 32'h100);
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0);
    chk("pend_hold_pc", bus.pc, 32'h100);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    ack1(32'h100);
    chk("pend_branch_pc", bus.pc, 32'h0FC);
    ack1(32'h0FC);
    chk("pend_cleared_pc", bus.pc, 32'h100);

    // Later strobe overwrites the pending one.
    cyc(1'b0, 1'b0, 1'b1, 32'd4, 1'b0, 26'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h80);
    ack1(32'h100);
    chk("pend_overwrite_pc", bus.pc, 32'h200);

    // Branch up to 0x1000_0000, then simultaneous strobes.
    exp_q.push_back(32'h200);
    cyc(1'b1, 1'b0, 1'b1, 32'h03FF_FF7F, 1'b0, 26'd0);
    chk("branch_far_pc", bus.pc, 32'h1000_0000);
    exp_q.push_back(32'h1000_0000);
    cyc(1'b1, 1'b0, 1'b1, 32'd5, 1'b1, 26'h40);
    chk("jump_prio_pc", bus.pc, 32'h1000_0100);

    // Wrap at the top of the address space.
    exp_q.push_back(32'h1000_0100);
    cyc(1'b1, 1'b0, 1'b1, 32'h3BFF_FFBE, 1'b0, 26'd0);
    chk("top_pc",       bus.pc,       32'hFFFF_FFFC);
    chk("top_pc_plus4", bus.pc_plus4, 32'h0);
    ack1(32'hFFFF_FFFC);
    chk("wrap_pc", bus.pc, 32'h0);

    // Enter WAIT with a pending branch, then reset.
    exp_q.push_back(32'h0);
    cyc(1'b1, 1'b1, 1'b1, 32'd10, 1'b0, 26'd0);
    chk("wait_req", {31'd0, bus.instr_req}, 32'd0);
    reset = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
    reset = 1'b0;
    chk("wrst_pc",     bus.pc, 32'h0);
    chk("wrst_req",    {31'd0, bus.instr_req},   32'd1);
    chk("wrst_fvalid", {31'd0, bus.fetch_valid}, 32'd0);
    chk("wrst_stalls", bus.stall_cycles, 32'h0);
    ack1(32'h0);
    chk("wrst_no_pend_pc", bus.pc, 32'h4);

    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
